// File: rtl/td4_exec_ctrl_if.sv
// Host/core-facing signal bundle for the TD4 execution controller.
// Parameters DIV_W and CYC_W must match those of the td4_exec_ctrl instance.
interface td4_exec_ctrl_if #(
    parameter int DIV_W = 16,
    parameter int CYC_W = 16
);
    // Control pulses RUN / HALT_REQ / STEP are level-sampled on every rising
    // CLK edge.  A pulse is a request that is high for exactly one cycle.
    // There is no ready/acknowledge: a request that does not apply to the
    // current state is dropped.  EN is the only "valid" indication: it is
    // high in exactly the cycles whose PC/OPCODE/IM word is executed.
    logic             RUN;
    logic             HALT_REQ;
    logic             STEP;
    logic [DIV_W-1:0] DIV;
    logic [3:0]       PC;
    logic [3:0]       OPCODE;
    logic [3:0]       IM;
    logic [3:0]       BP_ADDR;
    logic             BP_VALID;

    logic             EN;
    logic [1:0]       STATE;
    logic             HALTED;
    logic [1:0]       HALT_CAUSE;
    logic [CYC_W-1:0] CYCLES;

    // Host / core side: drives requests and observed instruction word
    modport master (
        output RUN, HALT_REQ, STEP, DIV, PC, OPCODE, IM, BP_ADDR, BP_VALID,
        input  EN, STATE, HALTED, HALT_CAUSE, CYCLES
    );

    // Controller side
    modport slave (
        input  RUN, HALT_REQ, STEP, DIV, PC, OPCODE, IM, BP_ADDR, BP_VALID,
        output EN, STATE, HALTED, HALT_CAUSE, CYCLES
    );
endinterface

// File: rtl/td4_exec_ctrl.sv
// TD4 execution controller: produces the datapath clock-enable EN and
// sequences IDLE / RUN / HALT / STEP, with a programmable issue divider,
// host halt, self-jump detection and a saturating executed-instruction count.
// Optional PC breakpoint is compiled in when TD4_BREAKPOINT_EN is defined.
module td4_exec_ctrl #(
    parameter int DIV_W = 16,
    parameter int CYC_W = 16
) (
    input  logic           CLK,
    input  logic           CLR,
    td4_exec_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2,
        S_STEP = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_HREQ = 2'd1;
    localparam logic [1:0] CAUSE_BP   = 2'd2;
    localparam logic [1:0] CAUSE_SJMP = 2'd3;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cause_q, cause_d;
    logic [CYC_W-1:0] cycles_q, cycles_d;

    logic issue;
    logic selfjmp;
    logic bp_hit;
    logic stop;
    logic en;

    // Issue when the prescaler has counted DIV cycles; DIV may change live,
    // so compare with >= rather than ==.
    assign issue   = (cnt_q >= bus.DIV);
    assign selfjmp = (bus.OPCODE == 4'hF) && (bus.IM == bus.PC);

`ifdef TD4_BREAKPOINT_EN
    logic bp_skip_q, bp_skip_d;
    logic resume;

    // Leaving HALT through RUN or STEP; HALT_REQ takes precedence there.
    assign resume = (state_q == S_HALT) && !bus.HALT_REQ && (bus.RUN || bus.STEP);
    assign bp_hit = bus.BP_VALID && (bus.PC == bus.BP_ADDR) && !bp_skip_q;

    // Skip flag lets the instruction sitting on the breakpoint execute once
    always_comb begin
        bp_skip_d = bp_skip_q;
        if (en) begin
            bp_skip_d = 1'b0;
        end else if (resume) begin
            bp_skip_d = 1'b1;
        end
    end

    // Skip flag register
    always_ff @(posedge CLK) begin
        if (CLR) begin
            bp_skip_q <= 1'b0;
        end else begin
            bp_skip_q <= bp_skip_d;
        end
    end
`else
    logic unused_bp;
    assign unused_bp = ^{bus.BP_ADDR, bus.BP_VALID};
    assign bp_hit    = 1'b0;
`endif

    assign stop = bus.HALT_REQ || bp_hit;

    // State and counter registers
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            cause_q  <= CAUSE_NONE;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cause_q  <= cause_d;
            cycles_q <= cycles_d;
        end
    end

    // Next-state, prescaler, halt cause and instruction counter
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cause_d  = cause_q;
        cycles_d = cycles_q;

        if (en && (cycles_q != {CYC_W{1'b1}})) begin
            cycles_d = cycles_q + CYC_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (bus.HALT_REQ) begin
                    state_d = S_HALT;
                    cause_d = CAUSE_HREQ;
                end else if (bus.RUN) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else if (bus.STEP) begin
                    state_d = S_STEP;
                end
            end

            S_RUN: begin
                if (!issue) begin
                    if (bus.HALT_REQ) begin
                        state_d = S_HALT;
                        cause_d = CAUSE_HREQ;
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                end else begin
                    cnt_d = '0;
                    if (bus.HALT_REQ) begin
                        state_d = S_HALT;
                        cause_d = CAUSE_HREQ;
                    end else if (bp_hit) begin
                        // Breakpoint instruction is not executed
                        state_d = S_HALT;
                        cause_d = CAUSE_BP;
                    end else if (selfjmp) begin
                        // Self-jump executes once, then the core parks
                        state_d = S_HALT;
                        cause_d = CAUSE_SJMP;
                    end
                end
            end

            S_HALT: begin
                if (bus.HALT_REQ) begin
                    state_d = S_HALT;
                end else if (bus.RUN) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    cause_d = CAUSE_NONE;
                end else if (bus.STEP) begin
                    state_d = S_STEP;
                end
            end

            S_STEP: begin
                // Single executed cycle; breakpoint and HALT_REQ not consulted
                state_d = S_HALT;
                if (selfjmp) begin
                    cause_d = CAUSE_SJMP;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Mealy clock-enable: executes in RUN issue cycles unless stopped, and in STEP
    always_comb begin
        en = 1'b0;
        if (!CLR) begin
            case (state_q)
                S_RUN:   en = issue && !stop;
                S_STEP:  en = 1'b1;
                default: en = 1'b0;
            endcase
        end
    end

    assign bus.EN         = en;
    assign bus.STATE      = state_q;
    assign bus.HALTED     = (state_q == S_HALT);
    assign bus.HALT_CAUSE = cause_q;
    assign bus.CYCLES     = cycles_q;

endmodule

// File: tb/tb_td4_exec_ctrl.sv
// Self-checking bench for td4_exec_ctrl: directed scenarios plus a random
// phase, all compared cycle by cycle against a behavioural model.
module tb_td4_exec_ctrl;
  localparam int DIV_W   = 16;
  localparam int CYC_W   = 8;
  localparam int CYC_MAX = (1 << CYC_W) - 1;
  localparam int ST_IDLE = 0;
  localparam int ST_RUN  = 1;
  localparam int ST_HALT = 2;
  localparam int ST_STEP = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  td4_exec_ctrl_if #(.DIV_W(DIV_W), .CYC_W(CYC_W)) bus();

  td4_exec_ctrl #(.DIV_W(DIV_W), .CYC_W(CYC_W)) dut (
    .CLK (clk),
    .CLR (clr),
    .bus (bus)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_err    = 0;
  int en_seen  = 0;

  // reference model state (plain integers)
  int m_state  = ST_IDLE;
  int m_cnt    = 0;
  int m_cause  = 0;
  int m_skip   = 0;
  int m_cycles = 0;
  int x_state, x_cnt, x_cause, x_skip, x_cycles;
  bit exp_en;

  logic [CYC_W+4:0] exp_q[$];

  // tiny core emulation: PC advances on every executed instruction
  logic [7:0] rom[16];
  int core_pc   = 0;
  bit core_mode = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_eval();
    bit issue, selfj, bp;
    issue = (m_cnt >= int'(bus.DIV));
    selfj = (bus.OPCODE == 4'hF) && (bus.IM == bus.PC);
`ifdef TD4_BREAKPOINT_EN
    bp = bus.BP_VALID && (bus.PC == bus.BP_ADDR) && (m_skip == 0);
`else
    bp = 1'b0;
`endif
    x_state = m_state; x_cnt = m_cnt; x_cause = m_cause;
    x_skip = m_skip; x_cycles = m_cycles;
    exp_en = 1'b0;
    if (clr) begin
      x_state = ST_IDLE; x_cnt = 0; x_cause = 0; x_skip = 0; x_cycles = 0;
    end else begin
      if (m_state == ST_IDLE) begin
        if (bus.HALT_REQ) begin x_state = ST_HALT; x_cause = 1; end
        else if (bus.RUN) begin x_state = ST_RUN; x_cnt = 0; end
        else if (bus.STEP) x_state = ST_STEP;
      end else if (m_state == ST_RUN) begin
        if (!issue) begin
          if (bus.HALT_REQ) begin x_state = ST_HALT; x_cause = 1; end
          else x_cnt = m_cnt + 1;
        end else begin
          x_cnt = 0;
          if (bus.HALT_REQ) begin x_state = ST_HALT; x_cause = 1; end
          else if (bp) begin x_state = ST_HALT; x_cause = 2; end
          else begin
            exp_en = 1'b1;
            if (selfj) begin x_state = ST_HALT; x_cause = 3; end
          end
        end
      end else if (m_state == ST_HALT) begin
        if (bus.HALT_REQ) x_state = ST_HALT;
        else if (bus.RUN) begin x_state = ST_RUN; x_cnt = 0; x_skip = 1; x_cause = 0; end
        else if (bus.STEP) begin x_state = ST_STEP; x_skip = 1; end
      end else begin
        exp_en = 1'b1;
        x_state = ST_HALT;
        if (selfj) x_cause = 3;
      end
      if (exp_en) begin
        x_skip = 0;
        if (m_cycles < CYC_MAX) x_cycles = m_cycles + 1;
      end
    end
  endtask

  task automatic model_commit();
    m_state = x_state; m_cnt = x_cnt; m_cause = x_cause;
    m_skip = x_skip; m_cycles = x_cycles;
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_prog();
    if (core_mode) begin
      bus.PC     = 4'(core_pc);
      bus.OPCODE = rom[core_pc][7:4];
      bus.IM     = rom[core_pc][3:0];
    end else begin
      bus.PC = 4'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        bus.OPCODE = 4'hF;
        bus.IM     = bus.PC;
      end else begin
        bus.OPCODE = 4'($urandom);
        bus.IM     = 4'($urandom);
      end
    end
  endtask

  // One clock cycle: check outputs mid-cycle, advance model after the edge
  task automatic tick();
    logic [CYC_W+4:0] w;
    apply_prog();
    @(negedge clk);
    model_eval();
    exp_q.push_back({2'(m_state), 2'(m_cause), exp_en, CYC_W'(m_cycles)});
    w = exp_q.pop_front();
    chk("en",     32'(bus.EN),         32'(w[CYC_W]));
    chk("state",  32'(bus.STATE),      32'(w[CYC_W+4:CYC_W+3]));
    chk("halted", 32'(bus.HALTED),     32'(w[CYC_W+4:CYC_W+3] == 2'd2));
    chk("cause",  32'(bus.HALT_CAUSE), 32'(w[CYC_W+2:CYC_W+1]));
    chk("cycles", 32'(bus.CYCLES),     32'(w[CYC_W-1:0]));
    if (bus.EN === 1'b1) en_seen++;
    @(posedge clk);
    #1;
    model_commit();
    if (exp_en && core_mode) begin
      if (rom[core_pc][7:4] == 4'hF) core_pc = int'(rom[core_pc][3:0]);
      else core_pc = (core_pc + 1) % 16;
    end
    bus.RUN = 1'b0; bus.HALT_REQ = 1'b0; bus.STEP = 1'b0;
  endtask

  task automatic wait_state(input int st, input int budget, input string tag);
    int n;
    n = 0;
    while (m_state != st && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.STATE), 32'(st));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit found;
    clr = 1'b1;
    bus.RUN = 1'b0; bus.HALT_REQ = 1'b0; bus.STEP = 1'b0;
    bus.DIV = '0; bus.BP_ADDR = 4'h0; bus.BP_VALID = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = {4'($urandom_range(0, 14)), 4'($urandom)};

    // reset, with a RUN pulse that must be ignored
    bus.RUN = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    tick();
    chk("reset_state", 32'(bus.STATE), 32'(ST_IDLE));
    chk("reset_cycles", 32'(bus.CYCLES), 32'd0);

    // DIV=0: EN every cycle after the RUN pulse
    bus.DIV = 0; bus.RUN = 1'b1;
    tick();
    en_seen = 0;
    repeat (5) tick();
    chk("div0_en_count", 32'(en_seen), 32'd5);
    chk("div0_cycles", 32'(bus.CYCLES), 32'd5);
    bus.HALT_REQ = 1'b1;
    tick();
    chk("hreq_state", 32'(bus.STATE), 32'(ST_HALT));
    chk("hreq_cause", 32'(bus.HALT_CAUSE), 32'd1);

    // DIV=3: EN every 4th cycle, then HALT_REQ landing on an issue cycle
    bus.DIV = 3; bus.RUN = 1'b1;
    tick();
    en_seen = 0;
    repeat (15) tick();
    chk("div3_en_count", 32'(en_seen), 32'd3);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (m_state == ST_RUN && m_cnt >= int'(bus.DIV)) begin
        bus.HALT_REQ = 1'b1;
        en_seen = 0;
        tick();
        found = 1'b1;
      end else begin
        tick();
      end
    end
    chk("issue_found", 32'(found), 32'd1);
    chk("halt_issue_en", 32'(en_seen), 32'd0);
    chk("halt_issue_state", 32'(bus.STATE), 32'(ST_HALT));
    chk("halt_issue_cause", 32'(bus.HALT_CAUSE), 32'd1);

    // three STEP pulses spaced 4 cycles
    en_seen = 0;
    repeat (3) begin
      bus.STEP = 1'b1;
      tick();
      repeat (3) tick();
    end
    chk("step_en_count", 32'(en_seen), 32'd3);
    chk("step_cycles", 32'(bus.CYCLES), 32'd11);
    chk("step_state", 32'(bus.STATE), 32'(ST_HALT));
    chk("step_cause", 32'(bus.HALT_CAUSE), 32'd1);

    // self-jump at address 7 (PC now 11: 11..15, 0..7 = 13 instructions)
    rom[7] = 8'hF7;
    bus.DIV = 0; bus.RUN = 1'b1;
    tick();
    en_seen = 0;
    wait_state(ST_HALT, 40, "sjmp_reach_halt");
    chk("sjmp_en_count", 32'(en_seen), 32'd13);
    chk("sjmp_cause", 32'(bus.HALT_CAUSE), 32'd3);
    chk("sjmp_cycles", 32'(bus.CYCLES), 32'd24);
    en_seen = 0;
    repeat (4) tick();
    chk("sjmp_quiet", 32'(en_seen), 32'd0);
    rom[7] = 8'h17;

`ifdef TD4_BREAKPOINT_EN
    // breakpoint at 4: from PC 7, 7..15, 0..3 = 13 instructions then stop
    bus.BP_ADDR = 4'h4; bus.BP_VALID = 1'b1; bus.RUN = 1'b1;
    tick();
    en_seen = 0;
    wait_state(ST_HALT, 60, "bp_reach_halt");
    chk("bp_en_count", 32'(en_seen), 32'd13);
    chk("bp_cause", 32'(bus.HALT_CAUSE), 32'd2);
    bus.RUN = 1'b1;
    tick();
    en_seen = 0;
    repeat (3) tick();
    chk("bp_resume_en", 32'(en_seen), 32'd3);
    chk("bp_resume_state", 32'(bus.STATE), 32'(ST_RUN));
    bus.HALT_REQ = 1'b1;
    tick();
    bus.BP_VALID = 1'b0;
`endif

    // random phase
    core_mode = 1'b0;
    for (int i = 0; i < 800; i++) begin
      clr          = ($urandom_range(0, 199) == 0);
      bus.RUN      = ($urandom_range(0, 7) == 0);
      bus.HALT_REQ = ($urandom_range(0, 29) == 0);
      bus.STEP     = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 49) == 0) bus.DIV = DIV_W'($urandom_range(0, 3));
      bus.BP_ADDR  = 4'($urandom);
      bus.BP_VALID = ($urandom_range(0, 3) == 0);
      tick();
    end
    clr = 1'b0; bus.BP_VALID = 1'b0;

    // saturation of the instruction counter
    clr = 1'b1;
    tick();
    clr = 1'b0;
    core_mode = 1'b1; core_pc = 0; bus.DIV = 0;
    bus.RUN = 1'b1;
    tick();
    repeat (CYC_MAX + 10) tick();
    chk("sat_cycles", 32'(bus.CYCLES), 32'(CYC_MAX));
    chk("sat_state", 32'(bus.STATE), 32'(ST_RUN));

    // CLR in the middle of RUN
    clr = 1'b1;
    en_seen = 0;
    tick();
    chk("clr_en", 32'(en_seen), 32'd0);
    chk("clr_state", 32'(bus.STATE), 32'(ST_IDLE));
    chk("clr_cycles", 32'(bus.CYCLES), 32'd0);
    chk("clr_cause", 32'(bus.HALT_CAUSE), 32'd0);
    clr = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
